// File: rtl/acfa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acfa_pkg
// Description : Shared definitions for the ACFA log drain: the drain state
//               encoding, the default frame header and the position of the
//               overflow flag inside the count word.
// Revision    : 1.0 - initial release
// ============================================================================
package acfa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_CNT   = 3'd2,
        ST_FETCH = 3'd3,
        ST_LATCH = 3'd4,
        ST_SEND  = 3'd5,
        ST_CSUM  = 3'd6,
        ST_FIN   = 3'd7
    } state_t;

    localparam logic [15:0] HDR_WORD_DEFAULT = 16'hACFA;
    localparam int          CNT_OVF_BIT      = 15;

endpackage : acfa_pkg
`default_nettype wire

// File: rtl/acfa_log_drain.sv
`default_nettype none
// ============================================================================
// Module      : acfa_log_drain
// Description : Drains the ACFA control-flow log. On trig it snapshots the log
//               pointer, then streams header, count word, every valid log
//               word (read through the synchronous memory port) and an XOR
//               checksum over a valid/ready interface, finally pulsing
//               log_clear together with done.
// Ports       : mclk, puc_rst       - clock, async active-high reset
//               trig, log_ptr       - start request, number of valid words
//               mem_ren/addr/rdata  - log memory read port (1-cycle latency)
//               tx_data/valid/ready - outgoing word stream
//               busy, done, log_clear - frame status
// Revision    : 1.0 - initial release
// ============================================================================
module acfa_log_drain
    import acfa_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          LOG_WORDS = 128,
    parameter logic [15:0] HDR_WORD  = HDR_WORD_DEFAULT
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              trig,
    input  logic [15:0]       log_ptr,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              log_clear
);

    localparam logic [15:0] c_log_words = 16'(LOG_WORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_n;
    logic              r_ovf;
    logic [ADDR_W:0]   r_idx;
    logic [15:0]       r_data;
    logic [15:0]       r_csum;
    logic [ADDR_W:0]   w_idx_inc;
    logic [15:0]       w_cnt_word;
    logic [15:0]       w_n_clamp;
    logic              w_hs;

    assign w_idx_inc = r_idx + 1'b1;
    assign w_n_clamp = (log_ptr > c_log_words) ? c_log_words : log_ptr;
    assign w_hs      = tx_valid & tx_ready;

    // Count word: clamped length with the overflow flag in the top bit.
    always_comb begin
        w_cnt_word              = r_n;
        w_cnt_word[CNT_OVF_BIT] = r_ovf;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // All outputs decode from the state register, so an asynchronous reset
    // forces them to zero immediately.
    always_comb begin
        w_state_nxt = r_state;
        tx_valid    = 1'b0;
        tx_data     = '0;
        mem_ren     = 1'b0;
        mem_addr    = '0;
        busy        = 1'b1;
        done        = 1'b0;
        log_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (trig) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = r_data;
                if (tx_ready) begin
                    w_state_nxt = ST_CNT;
                end
            end
            ST_CNT: begin
                tx_valid = 1'b1;
                tx_data  = r_data;
                if (tx_ready) begin
                    w_state_nxt = (r_n == 16'd0) ? ST_CSUM : ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_ren     = 1'b1;
                mem_addr    = r_idx[ADDR_W-1:0];
                w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = r_data;
                if (tx_ready) begin
                    w_state_nxt = (16'(w_idx_inc) == r_n) ? ST_CSUM : ST_FETCH;
                end
            end
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = r_csum;
                if (tx_ready) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                log_clear   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: snapshot, word holding register and running checksum.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_n    <= '0;
            r_ovf  <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
            r_csum <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (trig) begin
                        r_n    <= w_n_clamp;
                        r_ovf  <= (log_ptr > c_log_words);
                        r_idx  <= '0;
                        r_csum <= '0;
                        r_data <= HDR_WORD;
                    end
                end
                ST_HDR: begin
                    if (w_hs) begin
                        r_csum <= r_csum ^ r_data;
                        r_data <= w_cnt_word;
                    end
                end
                ST_CNT: begin
                    if (w_hs) begin
                        r_csum <= r_csum ^ r_data;
                    end
                end
                ST_LATCH: begin
                    r_data <= mem_rdata;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_csum <= r_csum ^ r_data;
                        r_idx  <= w_idx_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : acfa_log_drain
`default_nettype wire
